uart_txrx: RTL and testbench

Full-duplex UART core with a baud generator, a transmitter and a receiver sharing one system clock. It serialises a parallel byte to `serial_out` with start, parity and stop bits, and deserialises `serial_in` with parity and stop checking. It sits between a byte-level host interface and the board pins. Loopback (`serial_out` tied to `serial_in`) is the primary verification configuration.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 rtl/uart_txrx.sv | 115 +++++++++++
 tb/tb_uart_txrx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair.
package uart_pkg;

   localparam int unsigned CLOCKS_PER_BIT = 8;
   localparam int unsigned NUM_RX_SYNC    = 3;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } rx_state_e;

   // Start + data + optional parity + stop.
   function automatic int unsigned frame_len(input int unsigned width, input int unsigned parity);
      return width + parity + 2;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 3-flop synchroniser, start-edge resync and mid-bit sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned PARITY_ENABLED   = 1,
   parameter int unsigned PARITY_TYPE      = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_i,
   output logic [INPUT_DATA_WIDTH-1:0] data_o,
   output logic                        valid_o,
   output logic                        error_o
`ifdef FORMAL
   ,
   output rx_state_e                   state_o
`endif
);

   localparam int unsigned W    = INPUT_DATA_WIDTH;
   localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
   localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

   logic [NUM_RX_SYNC-1:0] sync_q;
   rx_state_e              state_q;
   logic [CntW-1:0]        cnt_q;
   logic [IdxW-1:0]        idx_q;
   logic [W-1:0]           shift_q;
   logic [W-1:0]           data_q;
   logic                   parity_ok_q;
   logic                   valid_q;
   logic                   error_q;
   logic                   rx_bit;
   logic                   fall;
   logic                   sample;
   logic                   exp_parity;

   // Edge taken across the last two stages so the start sample lands 3 + 4 clocks after the pin.
   assign rx_bit = sync_q[NUM_RX_SYNC-1];
   assign fall   = rx_bit & ~sync_q[NUM_RX_SYNC-2];

   assign sample = (state_q == StStart) ? (cnt_q == CntW'(CLOCKS_PER_BIT / 2 - 1))
                                        : (cnt_q == CntW'(CLOCKS_PER_BIT - 1));
   assign exp_parity = (PARITY_TYPE != 0) ? ~^shift_q : ^shift_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '1;
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         parity_ok_q <= 1'b0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         sync_q  <= {sync_q[NUM_RX_SYNC-2:0], serial_i};
         valid_q <= 1'b0;
         error_q <= 1'b0;

         if (state_q == StIdle || sample) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (fall) state_q <= StStart;
            end
            StStart: begin
               if (sample) begin
                  if (rx_bit) begin
                     state_q <= StIdle;
                  end else begin
                     state_q     <= StData;
                     idx_q       <= '0;
                     parity_ok_q <= 1'b1;
                  end
               end
            end
            StData: begin
               if (sample) begin
                  shift_q <= {rx_bit, shift_q[W-1:1]};
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == IdxW'(W - 1)) begin
                     state_q <= (PARITY_ENABLED != 0) ? StParity : StStop;
                  end
               end
            end
            StParity: begin
               if (sample) begin
                  parity_ok_q <= (rx_bit == exp_parity);
                  state_q     <= StStop;
               end
            end
            StStop: begin
               if (sample) begin
                  if (parity_ok_q && rx_bit) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     error_q <= 1'b1;
                  end
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign error_o = error_q;

`ifdef FORMAL
   assign state_o = state_q;
`endif

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: baud divider and transmitter here, receiver in uart_rx.
module uart_txrx
   import uart_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned PARITY_ENABLED   = 1,
   parameter int unsigned PARITY_TYPE      = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [INPUT_DATA_WIDTH-1:0] i_data,
   output logic                        o_busy,
   output logic                        serial_out,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error
`ifdef FORMAL
   ,
   output rx_state_e                   state,
   output logic                        baud_clk,
   output logic [frame_len(INPUT_DATA_WIDTH, PARITY_ENABLED)-1:0] shift_reg
`endif
);

   localparam int unsigned W        = INPUT_DATA_WIDTH;
   localparam int unsigned FrameLen = frame_len(W, PARITY_ENABLED);
   localparam int unsigned DivW     = $clog2(CLOCKS_PER_BIT);
   localparam int unsigned BitCntW  = $clog2(FrameLen);

   logic [DivW-1:0]     div_q;
   logic                baud_tick;
   logic [W-1:0]        tx_data_q;
   logic [FrameLen-1:0] shift_q;
   logic [FrameLen-1:0] frame;
   logic [BitCntW-1:0]  bits_left_q;
   logic                busy_q;
   logic                loaded_q;
   logic                parity_bit;

   assign baud_tick = (div_q == DivW'(CLOCKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset || baud_tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign parity_bit = (PARITY_TYPE != 0) ? ~^tx_data_q : ^tx_data_q;

   always_comb begin
      frame        = '1;
      frame[0]     = 1'b0;
      frame[W:1]   = tx_data_q;
      if (PARITY_ENABLED != 0) frame[W+1] = parity_bit;
   end

   // The line is the LSB of the shift register; shifting in ones leaves it idling high.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q      <= 1'b0;
         loaded_q    <= 1'b0;
         shift_q     <= '1;
         bits_left_q <= '0;
         tx_data_q   <= '0;
      end else if (!busy_q) begin
         if (enable) begin
            tx_data_q <= i_data;
            busy_q    <= 1'b1;
         end
      end else if (baud_tick) begin
         if (!loaded_q) begin
            loaded_q    <= 1'b1;
            shift_q     <= frame;
            bits_left_q <= BitCntW'(FrameLen - 1);
         end else if (bits_left_q == '0) begin
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
            shift_q  <= '1;
         end else begin
            shift_q     <= {1'b1, shift_q[FrameLen-1:1]};
            bits_left_q <= bits_left_q - 1'b1;
         end
      end
   end

   assign o_busy     = busy_q;
   assign serial_out = shift_q[0];

   uart_rx #(
      .INPUT_DATA_WIDTH(INPUT_DATA_WIDTH),
      .PARITY_ENABLED  (PARITY_ENABLED),
      .PARITY_TYPE     (PARITY_TYPE)
   ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .serial_i(serial_in),
      .data_o  (received_data),
      .valid_o (data_is_valid),
      .error_o (rx_error)
`ifdef FORMAL
      ,
      .state_o (state)
`endif
   );

`ifdef FORMAL
   assign baud_clk  = baud_tick;
   assign shift_reg = shift_q;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Loopback bench: queued expectations checked by independent line, timing and RX monitors.
module tb_uart_txrx;

   localparam int unsigned FrameLen = 11;

   logic       clk = 1'b0;
   logic       reset, enable, inject;
   logic [7:0] i_data;
   logic       o_busy, serial_out, serial_in, data_is_valid, rx_error;
   logic [7:0] received_data;

   logic       en_o;
   logic [7:0] d_o, rd_o;
   logic       busy_o, so_o, valid_o, err_o;

   always #5 clk = ~clk;

   assign serial_in = serial_out ^ inject;

   uart_txrx dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .i_data       (i_data),
      .o_busy       (o_busy),
      .serial_out   (serial_out),
      .serial_in    (serial_in),
      .received_data(received_data),
      .data_is_valid(data_is_valid),
      .rx_error     (rx_error)
   );

   uart_txrx #(.PARITY_TYPE(1)) dut_odd (
      .clk          (clk),
      .reset        (reset),
      .enable       (en_o),
      .i_data       (d_o),
      .o_busy       (busy_o),
      .serial_out   (so_o),
      .serial_in    (so_o),
      .received_data(rd_o),
      .data_is_valid(valid_o),
      .rx_error     (err_o)
   );

   typedef struct {
      bit         err;
      logic [7:0] data;
   } rx_exp_t;

   rx_exp_t             rx_q[$];
   logic [FrameLen-1:0] tx_q[$];
   logic [7:0]          last_good;
   int                  n_cmp = 0;
   int                  n_bad = 0;
   logic                tx_prev = 1'b1;
   logic                busy_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame as sent on the wire, bit k = k-th bit transmitted.
   function automatic logic [FrameLen-1:0] model_frame(input logic [7:0] d, input bit odd);
      int ones;
      bit par;
      ones = $countones(d);
      par  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return {1'b1, par, d, 1'b0};
   endfunction

   // RX scoreboard.
   always @(negedge clk) begin
      rx_exp_t e;
      if (!reset && (data_is_valid || rx_error)) begin
         check("rx_pulse_expected", 32'(rx_q.size() != 0), 32'd1);
         if (rx_q.size() != 0) begin
            e = rx_q.pop_front();
            check("rx_is_error", 32'(rx_error), 32'(e.err));
            check("rx_is_valid", 32'(data_is_valid), 32'(!e.err));
            check("rx_data", 32'(received_data), 32'(e.data));
         end
      end
   end

   // TX line monitor: samples each bit mid-period after a falling start edge.
   initial begin : tx_mon
      logic [FrameLen-1:0] got;
      bit aborted;
      forever begin
         @(negedge clk);
         if (reset) begin
            tx_prev = 1'b1;
         end else begin
            if (tx_prev && !serial_out) begin
               aborted = 1'b0;
               got     = '0;
               for (int c = 1; c <= 8 * (FrameLen - 1) + 4; c++) begin
                  @(negedge clk);
                  if (reset) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (c % 8 == 4) got[c/8] = serial_out;
               end
               if (!aborted) begin
                  check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
                  if (tx_q.size() != 0) check("tx_frame", 32'(got), 32'(tx_q.pop_front()));
               end
            end
            tx_prev = reset ? 1'b1 : serial_out;
         end
      end
   end

   // Busy window: start alignment, busy length and RX result latency.
   initial begin : busy_mon
      int align, total, pulse;
      bit aborted;
      forever begin
         @(negedge clk);
         if (!reset && o_busy && !busy_prev) begin
            align   = 0;
            total   = 0;
            pulse   = 0;
            aborted = 1'b0;
            for (int c = 1; c <= 200; c++) begin
               @(negedge clk);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               if (align == 0 && !serial_out) align = c;
               if (pulse == 0 && (data_is_valid || rx_error)) pulse = c;
               if (!o_busy) begin
                  total = c;
                  break;
               end
            end
            if (!aborted) begin
               check("tx_start_align_1_to_8", 32'(align >= 1 && align <= 8), 32'd1);
               check("busy_high_time", 32'(total), 32'(align + 88));
               check("rx_result_latency", 32'(pulse), 32'(align + 87));
            end
         end
         busy_prev = o_busy;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_start(input string name);
      int t = 0;
      while (serial_out !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check(name, 32'(serial_out), 32'd0);
   endtask

   task automatic send(input logic [7:0] d, input int flip);
      rx_exp_t e;
      int t = 0;
      @(negedge clk);
      while (o_busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("send_wait_idle", 32'(o_busy), 32'd0);
      enable = 1'b1;
      i_data = d;
      tx_q.push_back(model_frame(d, 1'b0));
      if (flip < 0) begin
         e.err = 1'b0;
         e.data = d;
         last_good = d;
      end else begin
         e.err = 1'b1;
         e.data = last_good;
      end
      rx_q.push_back(e);
      @(negedge clk);
      enable = 1'b0;
      i_data = 8'($urandom);
      if (flip >= 0) begin
         wait_start("inject_start_seen");
         repeat (8 * flip) @(negedge clk);
         inject = 1'b1;
         repeat (8) @(negedge clk);
         inject = 1'b0;
      end
   endtask

   task automatic odd_frame(input logic [7:0] d);
      logic [FrameLen-1:0] got;
      int t;
      @(negedge clk);
      en_o = 1'b1;
      d_o  = d;
      @(negedge clk);
      en_o = 1'b0;
      t = 0;
      while (so_o !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < int'(FrameLen); k++) begin
         repeat (k == 0 ? 4 : 8) @(negedge clk);
         got[k] = so_o;
      end
      check("odd_frame", 32'(got), 32'(model_frame(d, 1'b1)));
      t = 0;
      while (!valid_o && !err_o && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("odd_rx_valid", 32'(valid_o), 32'd1);
      check("odd_rx_error", 32'(err_o), 32'd0);
      check("odd_rx_data", 32'(rd_o), 32'(d));
      t = 0;
      while (busy_o && t < 20) begin
         @(negedge clk);
         t++;
      end
   endtask

   initial begin : stim
      logic [7:0] d;
      int flip, t;
      reset = 1'b1; enable = 1'b0; i_data = '0; inject = 1'b0;
      en_o = 1'b0; d_o = '0; last_good = '0;
      repeat (3) @(negedge clk);
      check("reset_serial_out", 32'(serial_out), 32'd1);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_received_data", 32'(received_data), 32'd0);
      check("reset_valid", 32'(data_is_valid), 32'd0);
      check("reset_error", 32'(rx_error), 32'd0);
      reset = 1'b0;

      odd_frame(8'h01);
      repeat (2) odd_frame(8'($urandom));

      send(8'hA5, -1);
      send(8'h3A, -1);
      repeat (30) @(negedge clk);
      enable = 1'b1;
      i_data = 8'hC3;
      @(negedge clk);
      enable = 1'b0;
      send(8'h3C, 9);
      send(8'($urandom), 10);
      send(8'h55, -1);

      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
         send(d, flip);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
      end

      // Abort mid-frame in the 5th data bit.
      send(8'h96, -1);
      wait_start("reset_test_start_seen");
      repeat (8 * 5 + 4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_serial_out", 32'(serial_out), 32'd1);
      check("midreset_busy", 32'(o_busy), 32'd0);
      check("midreset_valid", 32'(data_is_valid), 32'd0);
      check("midreset_error", 32'(rx_error), 32'd0);
      check("midreset_received_data", 32'(received_data), 32'd0);
      tx_q.delete();
      rx_q.delete();
      last_good = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      send(8'hFF, -1);

      t = 0;
      while ((o_busy || rx_q.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (20) @(negedge clk);
      check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
      check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
